// File: rtl/fp_maxmin_reduce_if.sv
// Stream bundle for fp_maxmin_reduce: input beat channel plus result channel.
// The master drives beats and accepts results; the slave is the reducer.
interface fp_maxmin_reduce_if #(
    parameter int Bits    = 16,
    parameter int IdxBits = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [Bits-1:0]    in_data;
    logic               in_last;
    logic               mode;
    logic               out_valid;
    logic               out_ready;
    logic [Bits-1:0]    out_data;
    logic [IdxBits-1:0] out_idx;
    logic               out_nan;
    logic               out_ovf;

    modport master (
        output in_valid, in_data, in_last, mode, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_nan, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, mode, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_nan, out_ovf
    );
endinterface

// File: rtl/fp_maxmin_reduce.sv
// Streaming FP max/min reducer: one compare/update per accepted beat, result
// (extreme value, its index, NaN and overflow flags) held until taken downstream.
module fp_maxmin_reduce #(
    parameter int Bits    = 16,
    parameter int ExpBits = 5,
    parameter int IdxBits = 8
) (
    input logic clk,
    input logic rst,
    fp_maxmin_reduce_if.slave io_bus
);
    localparam int MantBits = Bits - 1 - ExpBits;

    localparam logic [Bits-1:0]    SignBit  = {1'b1, {(Bits-1){1'b0}}};
    localparam logic [Bits-1:0]    ExpMask  = {1'b0, {ExpBits{1'b1}}, {MantBits{1'b0}}};
    localparam logic [Bits-1:0]    MantMask = {{(ExpBits+1){1'b0}}, {MantBits{1'b1}}};
    localparam logic [Bits-1:0]    QNaN     = {1'b0, {ExpBits{1'b1}}, 1'b1, {(MantBits-1){1'b0}}};
    localparam logic [IdxBits-1:0] MaxIdx   = {IdxBits{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [Bits-1:0]    r_acc;
    logic [IdxBits-1:0] r_idx;
    logic [IdxBits-1:0] r_count;
    logic [IdxBits-1:0] r_nanIdx;
    logic               r_mode;
    logic               r_nan;
    logic               r_ovf;
    logic               r_haveVal;

    logic               w_beat;
    logic               w_inReady;
    logic               w_outValid;
    logic               w_inNan;
    logic [Bits-1:0]    w_keyNew;
    logic [Bits-1:0]    w_keyAcc;
    logic               w_wins;

    // Sign-magnitude to monotonic unsigned key, so one unsigned compare orders all non-NaN values.
    assign w_keyNew = io_bus.in_data[Bits-1] ? ~io_bus.in_data : (io_bus.in_data | SignBit);
    assign w_keyAcc = r_acc[Bits-1] ? ~r_acc : (r_acc | SignBit);
    assign w_wins   = r_mode ? (w_keyNew < w_keyAcc) : (w_keyNew > w_keyAcc);

    assign w_inNan = ((io_bus.in_data & ExpMask) == ExpMask) && ((io_bus.in_data & MantMask) != '0);
    assign w_beat  = io_bus.in_valid && (r_state != DONE);

    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b1;
        w_outValid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_beat) begin
                    w_nextState = io_bus.in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_beat && io_bus.in_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_inReady  = 1'b0;
                w_outValid = 1'b1;
                if (io_bus.out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_nanIdx  <= '0;
            r_mode    <= 1'b0;
            r_nan     <= 1'b0;
            r_ovf     <= 1'b0;
            r_haveVal <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_beat) begin
                if (r_state == IDLE) begin
                    r_acc     <= io_bus.in_data;
                    r_idx     <= '0;
                    r_count   <= {{(IdxBits-1){1'b0}}, 1'b1};
                    r_nanIdx  <= '0;
                    r_mode    <= io_bus.mode;
                    r_nan     <= w_inNan;
                    r_ovf     <= 1'b0;
                    r_haveVal <= !w_inNan;
                end else begin
                    // r_count is also the (saturated) index of the arriving beat.
                    if (r_count == MaxIdx) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                    if (w_inNan) begin
                        r_nan <= 1'b1;
                        if (!r_nan) begin
                            r_nanIdx <= r_count;
                        end
                    end else if (!r_haveVal || w_wins) begin
                        r_acc     <= io_bus.in_data;
                        r_idx     <= r_count;
                        r_haveVal <= 1'b1;
                    end
                end
            end
        end
    end

    assign io_bus.in_ready  = w_inReady;
    assign io_bus.out_valid = w_outValid;
    assign io_bus.out_data  = r_nan ? QNaN : r_acc;
    assign io_bus.out_idx   = r_nan ? r_nanIdx : r_idx;
    assign io_bus.out_nan   = r_nan;
    assign io_bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_fp_maxmin_reduce.sv
// Bench for fp_maxmin_reduce (FP16, 2-bit index): directed frames checked against
// a real-valued reference model every cycle, plus hand-computed literal results.
module tb_fp_maxmin_reduce;
    localparam int Bits    = 16;
    localparam int ExpBits = 5;
    localparam int IdxBits = 2;
    localparam int MaxIdx  = (1 << IdxBits) - 1;

    typedef struct packed {
        logic [15:0]        data;
        logic [IdxBits-1:0] idx;
        logic               nan;
        logic               ovf;
    } result_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_maxmin_reduce_if #(.Bits(Bits), .IdxBits(IdxBits)) bus ();

    fp_maxmin_reduce #(.Bits(Bits), .ExpBits(ExpBits), .IdxBits(IdxBits)) dut (
        .clk   (clk),
        .rst   (rst),
        .io_bus(bus)
    );

    result_t expQ[$];
    int nCompared   = 0;
    int nMismatched = 0;

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fpToReal(input logic [15:0] x);
        int  e = int'(x[14:10]);
        int  m = int'(x[9:0]);
        real mag;
        if (e == 31)     mag = 1.0e300;
        else if (e == 0) mag = real'(m) * pow2(-24);
        else             mag = real'(1024 + m) * pow2(e - 25);
        return x[15] ? -mag : mag;
    endfunction

    function automatic bit isNan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // True when a strictly beats b; -0 sits just below +0.
    function automatic bit beats(input logic [15:0] a, input logic [15:0] b, input bit minMode);
        real ra = fpToReal(a);
        real rb = fpToReal(b);
        if (ra != rb) return minMode ? (ra < rb) : (ra > rb);
        if (a[15] != b[15]) return minMode ? a[15] : b[15];
        return 1'b0;
    endfunction

    function automatic result_t modelFrame(input logic [15:0] vals[$], input bit minMode);
        result_t r;
        bit          have   = 1'b0;
        bit          sawNan = 1'b0;
        logic [15:0] best   = 16'h0000;
        int          bestIdx = 0;
        int          nanIdx  = 0;
        for (int i = 0; i < vals.size(); i++) begin
            int pos = (i > MaxIdx) ? MaxIdx : i;
            if (isNan(vals[i])) begin
                if (!sawNan) nanIdx = pos;
                sawNan = 1'b1;
            end else if (!have || beats(vals[i], best, minMode)) begin
                best    = vals[i];
                bestIdx = pos;
                have    = 1'b1;
            end
        end
        r.nan  = sawNan;
        r.data = sawNan ? 16'h7E00 : best;
        r.idx  = IdxBits'(sawNan ? nanIdx : bestIdx);
        r.ovf  = (vals.size() > MaxIdx);
        return r;
    endfunction

    function automatic result_t mk(input logic [15:0] d, input int i, input bit n, input bit o);
        result_t r;
        r.data = d;
        r.idx  = IdxBits'(i);
        r.nan  = n;
        r.ovf  = o;
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input result_t exp);
        checkVal({name, "_data"}, 32'(bus.out_data), 32'(exp.data));
        checkVal({name, "_idx"},  32'(bus.out_idx),  32'(exp.idx));
        checkVal({name, "_nan"},  32'(bus.out_nan),  32'(exp.nan));
        checkVal({name, "_ovf"},  32'(bus.out_ovf),  32'(exp.ovf));
    endtask

    // A result is owed exactly while the bench holds an unconsumed expectation.
    always @(negedge clk) begin
        if (!rst) begin
            checkVal("out_valid", 32'(bus.out_valid), 32'(expQ.size() != 0));
            checkVal("in_ready",  32'(bus.in_ready),  32'(expQ.size() == 0));
            if (expQ.size() != 0 && bus.out_valid) begin
                checkOutput("model", expQ[0]);
            end
        end
    end

    task automatic waitAccept(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic applyStimulus(input string name, input logic [15:0] vals[$], input bit minMode,
                                 input int holdCycles, input bit toggleMode, input result_t lit);
        bit ok;
        for (int i = 0; i < vals.size(); i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vals[i];
            bus.in_last  = (i == vals.size() - 1);
            bus.mode     = (i > 0 && toggleMode) ? !minMode : minMode;
            waitAccept(ok);
            if (!ok) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        expQ.push_back(modelFrame(vals, minMode));
        @(negedge clk);
        checkVal({name, "_latency"}, 32'(bus.out_valid), 32'd1);
        checkOutput(name, lit);
        // Junk beats offered while the result is pending must be ignored.
        bus.in_valid = (holdCycles > 0);
        bus.in_data  = 16'h7FFF;
        bus.in_last  = 1'b1;
        repeat (holdCycles) @(negedge clk);
        if (holdCycles > 0) checkOutput({name, "_held"}, lit);
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        void'(expQ.pop_front());
        @(negedge clk);
        checkVal({name, "_released"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] v[$];
        bit ok;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_last   = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", mk(16'h0000, 0, 1'b0, 1'b0));
        checkVal("reset_valid", 32'(bus.out_valid), 32'd0);
        checkVal("reset_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        v = {16'h3C00, 16'h4000, 16'hC200};
        applyStimulus("max3", v, 1'b0, 0, 1'b0, mk(16'h4000, 1, 1'b0, 1'b0));
        applyStimulus("min3", v, 1'b1, 0, 1'b0, mk(16'hC200, 2, 1'b0, 1'b0));
        v = {16'h4000, 16'h4000};
        applyStimulus("tie", v, 1'b0, 0, 1'b0, mk(16'h4000, 0, 1'b0, 1'b0));
        v = {16'h8000, 16'h0000};
        applyStimulus("zeroMax", v, 1'b0, 0, 1'b0, mk(16'h0000, 1, 1'b0, 1'b0));
        applyStimulus("zeroMin", v, 1'b1, 0, 1'b0, mk(16'h8000, 0, 1'b0, 1'b0));
        v = {16'h3C00};
        applyStimulus("single", v, 1'b0, 0, 1'b0, mk(16'h3C00, 0, 1'b0, 1'b0));
        v = {16'h7E01, 16'h3C00, 16'h7C05};
        applyStimulus("nan", v, 1'b0, 0, 1'b0, mk(16'h7E00, 0, 1'b1, 1'b0));
        v = {16'h3C00};
        applyStimulus("afterNan", v, 1'b0, 0, 1'b0, mk(16'h3C00, 0, 1'b0, 1'b0));
        v = {16'h4000, 16'h7FFF, 16'h3C00};
        applyStimulus("nanMid", v, 1'b1, 0, 1'b0, mk(16'h7E00, 1, 1'b1, 1'b0));
        v = {16'hC000, 16'hBC00};
        applyStimulus("stall", v, 1'b0, 5, 1'b0, mk(16'hBC00, 1, 1'b0, 1'b0));
        v = {16'h4000, 16'h3C00, 16'h4200};
        applyStimulus("modeLatch", v, 1'b1, 0, 1'b1, mk(16'h3C00, 1, 1'b0, 1'b0));
        v = {16'hFC00, 16'h7C00, 16'h7BFF};
        applyStimulus("inf", v, 1'b0, 2, 1'b0, mk(16'h7C00, 1, 1'b0, 1'b0));
        v = {16'h3C00, 16'h3C01, 16'h3C02, 16'h3C03, 16'h3C04, 16'h4800};
        applyStimulus("ovf", v, 1'b0, 0, 1'b0, mk(16'h4800, 3, 1'b0, 1'b1));
        v = {16'h3C00, 16'h3C01};
        applyStimulus("ovfClear", v, 1'b0, 0, 1'b0, mk(16'h3C01, 1, 1'b0, 1'b0));

        // Abandon a frame with a mid-frame reset; no result may follow.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5000;
        bus.in_last  = 1'b0;
        bus.mode     = 1'b0;
        waitAccept(ok);
        bus.in_data  = 16'h5400;
        waitAccept(ok);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midReset", mk(16'h0000, 0, 1'b0, 1'b0));
        repeat (3) @(negedge clk);

        v = {16'h4400, 16'h4200};
        applyStimulus("postReset", v, 1'b1, 0, 1'b0, mk(16'h4200, 1, 1'b0, 1'b0));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
